// File: rtl/refresh_sequencer.sv
// refresh_sequencer: refresh initiator for the GC-DRAM macro.
// A free-running interval timer raises a refresh request. Each request sweeps every row as
// read -> capture -> write-back. Single-beat host commands are passed to the macro while idle.
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   host_*_i / host_*_o host command port (req/we/addr/wdata in; ready/rvalid/rdata out)
//   mem_*_o / mem_*_i   memory macro port (en/we/addr/wdata out; rdata in, one-cycle read latency)
//   refresh_active_o    a sweep is in progress
//   refresh_overrun_o   sticky flag: a tick arrived while a refresh was pending or running
module refresh_sequencer #(
    parameter int ADDR_BITS        = 7,
    parameter int DATA_W           = 32,
    parameter int NUM_ROWS         = 128,
    parameter int REFRESH_INTERVAL = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 host_req_i,
    input  logic                 host_we_i,
    input  logic [ADDR_BITS-1:0] host_addr_i,
    input  logic [DATA_W-1:0]    host_wdata_i,
    output logic                 host_ready_o,
    output logic                 host_rvalid_o,
    output logic [DATA_W-1:0]    host_rdata_o,
    output logic                 mem_en_o,
    output logic                 mem_we_o,
    output logic [ADDR_BITS-1:0] mem_addr_o,
    output logic [DATA_W-1:0]    mem_wdata_o,
    input  logic [DATA_W-1:0]    mem_rdata_i,
    output logic                 refresh_active_o,
    output logic                 refresh_overrun_o
);

    localparam int TMR_W = (REFRESH_INTERVAL > 2) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam logic [TMR_W-1:0]     TMR_RELOAD = TMR_W'(REFRESH_INTERVAL - 1);
    localparam logic [ADDR_BITS-1:0] LAST_ROW   = ADDR_BITS'(NUM_ROWS - 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] REF_RD  = 2'd1;
    localparam logic [1:0] REF_CAP = 2'd2;
    localparam logic [1:0] REF_WB  = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [ADDR_BITS-1:0] row_q, row_d;
    logic [DATA_W-1:0]    buf_q, buf_d;
    logic                 pending_q, pending_d;
    logic                 overrun_q, overrun_d;
    logic                 rvalid_q, rvalid_d;
    logic                 tick;

    assign tick    = (timer_q == '0);
    assign timer_d = tick ? TMR_RELOAD : timer_q - 1'b1;

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        buf_d        = buf_q;
        // A tick always leaves a request behind; it is an overrun if the previous
        // one has not been picked up yet or a sweep is still running.
        pending_d    = pending_q | tick;
        overrun_d    = overrun_q | (tick & (pending_q | (state_q != IDLE)));
        mem_en_o     = 1'b0;
        mem_we_o     = 1'b0;
        mem_addr_o   = row_q;
        mem_wdata_o  = buf_q;
        host_ready_o = 1'b0;

        case (state_q)
            IDLE: begin
                if (pending_q) begin
                    state_d   = REF_RD;
                    // A tick landing on the very cycle the request is consumed re-arms it.
                    pending_d = tick;
                end else begin
                    host_ready_o = 1'b1;
                    if (host_req_i) begin
                        mem_en_o    = 1'b1;
                        mem_we_o    = host_we_i;
                        mem_addr_o  = host_addr_i;
                        mem_wdata_o = host_wdata_i;
                    end
                end
            end
            REF_RD: begin
                mem_en_o = 1'b1;
                state_d  = REF_CAP;
            end
            REF_CAP: begin
                buf_d   = mem_rdata_i;
                state_d = REF_WB;
            end
            REF_WB: begin
                mem_en_o = 1'b1;
                mem_we_o = 1'b1;
                if (row_q == LAST_ROW) begin
                    row_d   = '0;
                    state_d = IDLE;
                end else begin
                    row_d   = row_q + 1'b1;
                    state_d = REF_RD;
                end
            end
            default: state_d = IDLE;
        endcase

        rvalid_d = host_ready_o & host_req_i & ~host_we_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            timer_q   <= TMR_RELOAD;
            row_q     <= '0;
            buf_q     <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            rvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            row_q     <= row_d;
            buf_q     <= buf_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            rvalid_q  <= rvalid_d;
        end
    end

    assign host_rvalid_o     = rvalid_q;
    assign host_rdata_o      = mem_rdata_i;
    assign refresh_active_o  = (state_q != IDLE);
    assign refresh_overrun_o = overrun_q;

endmodule

// File: tb/tb_refresh_sequencer.sv
module tb_refresh_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // ---------------- instance A: interval 500 ----------------
    logic        rst_a = 1'b1;
    logic        preload = 1'b1;
    logic        req_a = 1'b0, we_a = 1'b0;
    logic [6:0]  haddr_a = '0;
    logic [31:0] hwdata_a = '0;
    logic        ready_a, rvalid_a, mem_en_a, mem_we_a, active_a, overrun_a;
    logic [31:0] hrdata_a, mem_wdata_a, mem_rdata_a;
    logic [6:0]  mem_addr_a;

    refresh_sequencer #(.ADDR_BITS(7), .DATA_W(32), .NUM_ROWS(128), .REFRESH_INTERVAL(500)) dut (
        .clk(clk), .rst(rst_a),
        .host_req_i(req_a), .host_we_i(we_a), .host_addr_i(haddr_a), .host_wdata_i(hwdata_a),
        .host_ready_o(ready_a), .host_rvalid_o(rvalid_a), .host_rdata_o(hrdata_a),
        .mem_en_o(mem_en_a), .mem_we_o(mem_we_a), .mem_addr_o(mem_addr_a),
        .mem_wdata_o(mem_wdata_a), .mem_rdata_i(mem_rdata_a),
        .refresh_active_o(active_a), .refresh_overrun_o(overrun_a));

    logic [31:0] mem_a [128];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 128; i++) mem_a[i] <= 32'h1000 + 32'(i);
            mem_rdata_a <= '0;
        end else if (mem_en_a) begin
            if (mem_we_a) mem_a[mem_addr_a] <= mem_wdata_a;
            else          mem_rdata_a <= mem_a[mem_addr_a];
        end
    end

    int ecnt = 0;
    always @(posedge clk or posedge rst_a) begin
        if (rst_a) ecnt <= 0;
        else       ecnt <= ecnt + 1;
    end

    // Sweep monitor: each row must be read, then written back with its stored value.
    logic mon_en = 1'b0;
    int mon_row = 0, mon_ph = 0, mon_bad = 0, rd_n = 0, wr_n = 0;

    function automatic logic [31:0] exp_val(input int r);
        return (r == 5) ? 32'hA5A5A5A5 : 32'h1000 + 32'(r);
    endfunction

    always @(negedge clk) begin
        if (mon_en && mem_en_a) begin
            if (!mem_we_a) begin
                rd_n++;
                if (32'(mem_addr_a) != 32'(mon_row) || mon_ph != 0) mon_bad++;
                mon_ph = 1;
            end else begin
                wr_n++;
                if (32'(mem_addr_a) != 32'(mon_row) || mem_wdata_a != exp_val(mon_row) || mon_ph != 1)
                    mon_bad++;
                mon_ph = 0;
                mon_row++;
            end
        end
    end

    // ---------------- instance B: interval 300 ----------------
    logic        rst_b = 1'b1;
    logic        req_b = 1'b0, we_b = 1'b0;
    logic [6:0]  haddr_b = '0;
    logic [31:0] hwdata_b = '0;
    logic        ready_b, rvalid_b, mem_en_b, mem_we_b, active_b, overrun_b;
    logic [31:0] hrdata_b, mem_wdata_b, mem_rdata_b;
    logic [6:0]  mem_addr_b;

    refresh_sequencer #(.ADDR_BITS(7), .DATA_W(32), .NUM_ROWS(128), .REFRESH_INTERVAL(300)) dut_b (
        .clk(clk), .rst(rst_b),
        .host_req_i(req_b), .host_we_i(we_b), .host_addr_i(haddr_b), .host_wdata_i(hwdata_b),
        .host_ready_o(ready_b), .host_rvalid_o(rvalid_b), .host_rdata_o(hrdata_b),
        .mem_en_o(mem_en_b), .mem_we_o(mem_we_b), .mem_addr_o(mem_addr_b),
        .mem_wdata_o(mem_wdata_b), .mem_rdata_i(mem_rdata_b),
        .refresh_active_o(active_b), .refresh_overrun_o(overrun_b));

    logic [31:0] mem_b [128];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 128; i++) mem_b[i] <= 32'h2000 + 32'(i);
            mem_rdata_b <= '0;
        end else if (mem_en_b) begin
            if (mem_we_b) mem_b[mem_addr_b] <= mem_wdata_b;
            else          mem_rdata_b <= mem_b[mem_addr_b];
        end
    end

    int cyc_b = 0;
    always @(posedge clk or posedge rst_b) begin
        if (rst_b) cyc_b <= 0;
        else       cyc_b <= cyc_b + 1;
    end

    logic b_done = 1'b0;

    initial begin
        while (cyc_b < 300 || rst_b) step;
        chk("b_tick_pending_ready", ready_b, 0);
        chk("b_tick_active", active_b, 0);
        step;
        chk("b_sweep_start", active_b, 1);
        while (cyc_b < 599) step;
        chk("b_overrun_before", overrun_b, 0);
        step;
        chk("b_overrun_midsweep", overrun_b, 1);
        while (cyc_b < 1500) step;
        chk("b_overrun_sticky", overrun_b, 1);
        b_done = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog ecnt=%0d", ecnt);
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence on instance A ----------------
    initial begin
        int n;
        int rdy_seen;
        repeat (3) step;
        chk("rst_mem_en", mem_en_a, 0);
        chk("rst_mem_we", mem_we_a, 0);
        chk("rst_active", active_a, 0);
        chk("rst_rvalid", rvalid_a, 0);
        chk("rst_overrun", overrun_a, 0);
        chk("rst_ready", ready_a, 1);
        rst_a = 1'b0; rst_b = 1'b0; preload = 1'b0;

        // Host write then read of row 5.
        step;
        req_a = 1'b1; we_a = 1'b1; haddr_a = 7'd5; hwdata_a = 32'hA5A5A5A5;
        #1;
        chk("wr_ready", ready_a, 1);
        chk("wr_mem_en", mem_en_a, 1);
        chk("wr_mem_we", mem_we_a, 1);
        chk("wr_mem_addr", mem_addr_a, 5);
        chk("wr_mem_wdata", mem_wdata_a, 32'hA5A5A5A5);
        step;
        we_a = 1'b0;
        #1;
        chk("rd_mem_en", mem_en_a, 1);
        chk("rd_mem_we", mem_we_a, 0);
        chk("wr_no_rvalid", rvalid_a, 0);
        step;
        req_a = 1'b0;
        #1;
        chk("rd_rvalid", rvalid_a, 1);
        chk("rd_rdata", hrdata_a, 32'hA5A5A5A5);
        chk("idle_mem_en", mem_en_a, 0);
        step;
        chk("rd_rvalid_drop", rvalid_a, 0);

        // Periodic sweep, idle host.
        while (ecnt < 499) step;
        chk("t499_ready", ready_a, 1);
        step;
        chk("t500_ready", ready_a, 0);
        chk("t500_active", active_a, 0);
        chk("t500_mem_en", mem_en_a, 0);
        step;
        mon_en = 1'b1;
        chk("t501_active", active_a, 1);
        chk("t501_mem_en", mem_en_a, 1);
        chk("t501_mem_we", mem_we_a, 0);
        chk("t501_addr", mem_addr_a, 0);
        n = 0;
        while (active_a && n < 1000) begin n++; step; end
        mon_en = 1'b0;
        chk("sweep_len", n, 384);
        chk("sweep_end_edge", ecnt, 885);
        chk("sweep_bad", mon_bad, 0);
        chk("sweep_reads", rd_n, 128);
        chk("sweep_writes", wr_n, 128);
        chk("sweep_overrun", overrun_a, 0);

        // Host request held across a sweep.
        while (ecnt < 1000) step;
        req_a = 1'b1; we_a = 1'b0; haddr_a = 7'd7;
        #1;
        chk("hold_pending_ready", ready_a, 0);
        step;
        n = 0; rdy_seen = 0;
        while (active_a && n < 1000) begin
            n++;
            if (ready_a) rdy_seen++;
            step;
        end
        chk("hold_sweep_len", n, 384);
        chk("hold_ready_seen", rdy_seen, 0);
        chk("hold_accept_ready", ready_a, 1);
        chk("hold_accept_en", mem_en_a, 1);
        chk("hold_accept_addr", mem_addr_a, 7);
        step;
        req_a = 1'b0;
        #1;
        chk("hold_rvalid", rvalid_a, 1);
        chk("hold_rdata", hrdata_a, 32'h1007);

        // Host request in the timer==0 cycle.
        while (ecnt < 1499) step;
        req_a = 1'b1; we_a = 1'b1; haddr_a = 7'd9; hwdata_a = 32'h12345678;
        #1;
        chk("tick_host_ready", ready_a, 1);
        chk("tick_host_en", mem_en_a, 1);
        chk("tick_host_addr", mem_addr_a, 9);
        step;
        req_a = 1'b0;
        #1;
        chk("tick_next_ready", ready_a, 0);
        chk("tick_next_en", mem_en_a, 0);
        step;
        chk("tick_refrd_active", active_a, 1);
        chk("tick_refrd_en", mem_en_a, 1);
        chk("tick_refrd_we", mem_we_a, 0);
        chk("tick_refrd_addr", mem_addr_a, 0);

        // Reset mid-sweep at row 40.
        while (ecnt < 1621) step;
        chk("row40_addr", mem_addr_a, 40);
        chk("row40_rd", mem_we_a, 0);
        rst_a = 1'b1;
        #1;
        chk("mrst_mem_en", mem_en_a, 0);
        chk("mrst_mem_we", mem_we_a, 0);
        chk("mrst_addr", mem_addr_a, 0);
        chk("mrst_wdata", mem_wdata_a, 0);
        chk("mrst_active", active_a, 0);
        chk("mrst_rvalid", rvalid_a, 0);
        chk("mrst_overrun", overrun_a, 0);
        step;
        rst_a = 1'b0;
        while (ecnt < 499) step;
        chk("re_t499_ready", ready_a, 1);
        chk("re_t499_active", active_a, 0);
        step;
        chk("re_t500_ready", ready_a, 0);
        step;
        chk("re_t501_active", active_a, 1);
        chk("re_t501_addr", mem_addr_a, 0);

        n = 0;
        while (!b_done && n < 5000) begin n++; step; end
        chk("b_done", b_done, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
